video_timing: RTL and testbench

VIDEO_TIMING -- requirements
Module: video_timing

---
 rtl/video_timing.sv | 126 ++++++++++++
 tb/tb_video_timing.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// Raster timing generator: pixel/line counters, registered de/sync/frame_start,
// and a one-outstanding line-prefetch request with sticky overrun detection.
module video_timing #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        fetch_req,
  output logic [9:0]  fetch_line,
  input  logic        fetch_ack,
  output logic        fetch_ovr
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] X_LAST = 11'(HT - 1);
  localparam logic [10:0] X_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  Y_LAST = 10'(VT - 1);
  localparam logic [9:0]  Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Cleared by reset so the first edge after reset presents (0,0) instead of advancing.
  logic        running;

  logic [10:0] x_nxt;
  logic [9:0]  y_nxt;
  logic [9:0]  line_nxt;
  logic        de_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        fs_nxt;
  logic        fetch_due;
  logic        req_nxt;
  logic [9:0]  fline_nxt;
  logic        ovr_nxt;

  // Next-state: all decodes are made on the coordinate about to be presented.
  always_comb begin
    x_nxt     = '0;
    y_nxt     = '0;
    line_nxt  = '0;
    de_nxt    = 1'b0;
    hs_nxt    = ~HS_POL;
    vs_nxt    = ~VS_POL;
    fs_nxt    = 1'b0;
    fetch_due = 1'b0;
    req_nxt   = fetch_req;
    fline_nxt = fetch_line;
    ovr_nxt   = fetch_ovr;

    if (running) begin
      if (x == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y == Y_LAST) ? '0 : y + 10'd1;
      end else begin
        x_nxt = x + 11'd1;
        y_nxt = y;
      end
    end

    line_nxt  = (y_nxt == Y_LAST) ? '0 : y_nxt + 10'd1;
    de_nxt    = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    hs_nxt    = (x_nxt >= HS_ON && x_nxt < HS_OFF) ? HS_POL : ~HS_POL;
    vs_nxt    = (y_nxt >= VS_ON && y_nxt < VS_OFF) ? VS_POL : ~VS_POL;
    fs_nxt    = (x_nxt == '0) && (y_nxt == '0);
    fetch_due = (x_nxt == X_ACT) && (line_nxt < Y_ACT);

    // A new fetch supersedes a pending one; an ack on that same edge retires the old one cleanly.
    if (fetch_due) begin
      req_nxt   = 1'b1;
      fline_nxt = line_nxt;
      if (fetch_req && !fetch_ack) begin
        ovr_nxt = 1'b1;
      end
    end else if (fetch_req && fetch_ack) begin
      req_nxt = 1'b0;
    end
  end

  // Output and state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      running     <= 1'b0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      fetch_req   <= 1'b0;
      fetch_line  <= '0;
      fetch_ovr   <= 1'b0;
    end else begin
      running     <= 1'b1;
      x           <= x_nxt;
      y           <= y_nxt;
      de          <= de_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      frame_start <= fs_nxt;
      fetch_req   <= req_nxt;
      fetch_line  <= fline_nxt;
      fetch_ovr   <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing using a reduced raster so whole frames fit in a short run;
// expectations come from a frame-position model built from the timing formulas.
module tb_video_timing;

  localparam int unsigned H_ACTIVE = 20;
  localparam int unsigned H_FP     = 4;
  localparam int unsigned H_SYNC   = 6;
  localparam int unsigned H_BP     = 5;
  localparam int unsigned V_ACTIVE = 12;
  localparam int unsigned V_FP     = 3;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 3;
  localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FT       = HT * VT;
  localparam logic        HS_POL   = 1'b0;
  localparam logic        VS_POL   = 1'b1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        fetch_ack = 1'b0;
  logic [10:0] x;
  logic [9:0]  y;
  logic        de, hsync, vsync, frame_start, fetch_req, fetch_ovr;
  logic [9:0]  fetch_line;

  int tests_run = 0;
  int tests_failed = 0;

  video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .CLK(CLK), .RST(RST), .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .fetch_req(fetch_req), .fetch_line(fetch_line),
    .fetch_ack(fetch_ack), .fetch_ovr(fetch_ovr)
  );

  always #5 CLK = ~CLK;

  // Reference: linear position within the frame plus the pending-fetch bookkeeping.
  function automatic logic exp_de(int unsigned p);
    return ((p % HT) < H_ACTIVE) && ((p / HT) < V_ACTIVE);
  endfunction

  function automatic logic exp_hs(int unsigned p);
    int unsigned xx = p % HT;
    return (xx >= H_ACTIVE + H_FP && xx < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
  endfunction

  function automatic logic exp_vs(int unsigned p);
    int unsigned yy = p / HT;
    return (yy >= V_ACTIVE + V_FP && yy < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
  endfunction

  function automatic int unsigned next_line(int unsigned p);
    return ((p / HT) + 1) % VT;
  endfunction

  function automatic logic fetch_due_at(int unsigned p);
    return ((p % HT) == H_ACTIVE) && (next_line(p) < V_ACTIVE);
  endfunction

  function automatic int unsigned next_pos(logic run, int unsigned p);
    return run ? (p + 1) % FT : 0;
  endfunction

  logic        m_run = 1'b0;
  int unsigned m_pos = 0;
  logic        m_req = 1'b0;
  logic [9:0]  m_line = '0;
  logic        m_ovr = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      m_run  <= 1'b0;
      m_pos  <= 0;
      m_req  <= 1'b0;
      m_line <= '0;
      m_ovr  <= 1'b0;
    end else begin
      m_run <= 1'b1;
      m_pos <= next_pos(m_run, m_pos);
      if (fetch_due_at(next_pos(m_run, m_pos))) begin
        m_req  <= 1'b1;
        m_line <= 10'(next_line(next_pos(m_run, m_pos)));
        if (m_req && !fetch_ack) m_ovr <= 1'b1;
      end else if (m_req && fetch_ack) begin
        m_req <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic apply_reset(int unsigned n);
    RST = 1'b1;
    repeat (n) tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [36:0] a, e;
    RST = 1'b1;
    fetch_ack = 1'b1;
    e = {11'd0, 10'd0, 1'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, 10'd0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      tick();
      a = {x, y, de, hsync, vsync, frame_start, fetch_req, fetch_line, fetch_ovr};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: got %h want %h", i, a, e);
      end
    end
    RST = 1'b0;
    fetch_ack = 1'b0;
    tick();
    tests_run++;
    if ({x, y, de, frame_start} !== {11'd0, 10'd0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_release: got x=%0d y=%0d de=%b fs=%b want 0 0 1 1", x, y, de, frame_start);
    end
    tick();
    tests_run++;
    if ({x, y, frame_start} !== {11'd1, 10'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL first_step: got x=%0d y=%0d fs=%b want 1 0 0", x, y, frame_start);
    end
  endtask

  task automatic test_random_frames();
    logic [36:0] a, e;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
    int fs_first = -1, fs_second = -1;
    fetch_ack = 1'b0;
    apply_reset(2);
    for (int c = 0; c < int'(2 * FT); c++) begin
      tick();
      e = {11'(m_pos % HT), 10'(m_pos / HT), exp_de(m_pos), exp_hs(m_pos), exp_vs(m_pos),
           (m_pos == 0), m_req, m_line, m_ovr};
      a = {x, y, de, hsync, vsync, frame_start, fetch_req, fetch_line, fetch_ovr};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL random_cycle %0d: got %h want %h", c, a, e);
      end
      if (de === 1'b1) de_cnt++;
      if (hsync === HS_POL) hs_cnt++;
      if (vsync === VS_POL) vs_cnt++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end
      fetch_ack = ($urandom_range(0, 15) == 0);
    end
    fetch_ack = 1'b0;
    tests_run++;
    if (de_cnt != int'(2 * H_ACTIVE * V_ACTIVE)) begin
      tests_failed++;
      $display("FAIL de_count: got %0d want %0d", de_cnt, 2 * H_ACTIVE * V_ACTIVE);
    end
    tests_run++;
    if (hs_cnt != int'(2 * VT * H_SYNC)) begin
      tests_failed++;
      $display("FAIL hsync_count: got %0d want %0d", hs_cnt, 2 * VT * H_SYNC);
    end
    tests_run++;
    if (vs_cnt != int'(2 * HT * V_SYNC)) begin
      tests_failed++;
      $display("FAIL vsync_count: got %0d want %0d", vs_cnt, 2 * HT * V_SYNC);
    end
    tests_run++;
    if (fs_cnt != 2 || fs_first != 0 || fs_second != int'(FT)) begin
      tests_failed++;
      $display("FAIL frame_period: got count %0d at %0d,%0d want 2 at 0,%0d",
               fs_cnt, fs_first, fs_second, FT);
    end
  endtask

  task automatic test_sync_edges();
    logic prev_hs, prev_vs;
    int hs_edges = 0, vs_edges = 0;
    fetch_ack = 1'b1;
    apply_reset(2);
    tick();
    prev_hs = hsync;
    prev_vs = vsync;
    for (int c = 0; c < int'(FT); c++) begin
      tick();
      if (vsync !== prev_vs) begin
        vs_edges++;
        tests_run++;
        if (vsync === VS_POL) begin
          if (x !== 11'd0 || y !== 10'(V_ACTIVE + V_FP)) begin
            tests_failed++;
            $display("FAIL vsync_rise: got x=%0d y=%0d want 0 %0d", x, y, V_ACTIVE + V_FP);
          end
        end else if (x !== 11'd0 || y !== 10'(V_ACTIVE + V_FP + V_SYNC)) begin
          tests_failed++;
          $display("FAIL vsync_fall: got x=%0d y=%0d want 0 %0d", x, y, V_ACTIVE + V_FP + V_SYNC);
        end
      end
      if (hsync !== prev_hs) begin
        hs_edges++;
        tests_run++;
        if (hsync === HS_POL) begin
          if (x !== 11'(H_ACTIVE + H_FP)) begin
            tests_failed++;
            $display("FAIL hsync_rise: got x=%0d want %0d", x, H_ACTIVE + H_FP);
          end
        end else if (x !== 11'(H_ACTIVE + H_FP + H_SYNC)) begin
          tests_failed++;
          $display("FAIL hsync_fall: got x=%0d want %0d", x, H_ACTIVE + H_FP + H_SYNC);
        end
      end
      prev_hs = hsync;
      prev_vs = vsync;
    end
    tests_run++;
    if (vs_edges != 2 || hs_edges != int'(2 * VT)) begin
      tests_failed++;
      $display("FAIL sync_edge_count: got vs=%0d hs=%0d want 2 %0d", vs_edges, hs_edges, 2 * VT);
    end
    fetch_ack = 1'b0;
  endtask

  task automatic test_fetch_ack_high();
    logic prev_req = 1'b0;
    logic seen_wrap = 1'b0;
    int nreq = 0;
    int unsigned nl;
    fetch_ack = 1'b1;
    apply_reset(2);
    for (int c = 0; c < int'(FT); c++) begin
      tick();
      if (fetch_req === 1'b1) begin
        nreq++;
        nl = (int'(y) + 1) % VT;
        tests_run++;
        if (prev_req !== 1'b0 || x !== 11'(H_ACTIVE) || fetch_line !== 10'(nl) || nl >= V_ACTIVE) begin
          tests_failed++;
          $display("FAIL fetch_pulse: got x=%0d y=%0d line=%0d prev_req=%b want x=%0d line=%0d",
                   x, y, fetch_line, prev_req, H_ACTIVE, nl);
        end
        if (y == 10'(VT - 1) && fetch_line == 10'd0) seen_wrap = 1'b1;
      end
      prev_req = fetch_req;
    end
    tests_run++;
    if (nreq != int'(V_ACTIVE) || seen_wrap !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_count: got %0d wrap=%b want %0d wrap=1", nreq, seen_wrap, V_ACTIVE);
    end
    fetch_ack = 1'b0;
  endtask

  task automatic test_overrun();
    logic found = 1'b0;
    logic dropped = 1'b0;
    logic [9:0] first_line;
    fetch_ack = 1'b0;
    apply_reset(2);
    for (int c = 0; c < int'(3 * HT); c++) begin
      tick();
      if (fetch_req === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL overrun_wait: got no fetch_req want fetch_req within %0d cycles", 3 * HT);
    end
    first_line = fetch_line;
    for (int k = 1; k <= int'(HT); k++) begin
      tick();
      if (fetch_req !== 1'b1) dropped = 1'b1;
      if (k == int'(HT) - 1) begin
        tests_run++;
        if (fetch_ovr !== 1'b0) begin
          tests_failed++;
          $display("FAIL overrun_early: got ovr=%b want 0", fetch_ovr);
        end
      end
    end
    tests_run++;
    if (dropped || fetch_line !== first_line + 10'd1 || x !== 11'(H_ACTIVE) || fetch_ovr !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun: got dropped=%b line=%0d x=%0d ovr=%b want 0 %0d %0d 1",
               dropped, fetch_line, x, fetch_ovr, first_line + 10'd1, H_ACTIVE);
    end
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    tests_run++;
    if (fetch_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_ack: got req=%b want 0", fetch_req);
    end
    repeat (HT) tick();
    tests_run++;
    if (fetch_ovr !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_sticky: got ovr=%b want 1", fetch_ovr);
    end
  endtask

  task automatic test_ack_on_due();
    logic found = 1'b0;
    fetch_ack = 1'b0;
    apply_reset(2);
    for (int c = 0; c < int'(3 * HT); c++) begin
      tick();
      if (fetch_req === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    repeat (HT - 1) tick();
    tests_run++;
    if (!found || fetch_req !== 1'b1 || x !== 11'(H_ACTIVE - 1)) begin
      tests_failed++;
      $display("FAIL ackdue_setup: got found=%b req=%b x=%0d want 1 1 %0d", found, fetch_req, x, H_ACTIVE - 1);
    end
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    tests_run++;
    if (fetch_req !== 1'b1 || fetch_line !== 10'd2 || fetch_ovr !== 1'b0 || x !== 11'(H_ACTIVE)) begin
      tests_failed++;
      $display("FAIL ackdue_new: got req=%b line=%0d ovr=%b x=%0d want 1 2 0 %0d",
               fetch_req, fetch_line, fetch_ovr, x, H_ACTIVE);
    end
    tick();
    tests_run++;
    if (fetch_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL ackdue_hold: got req=%b want 1", fetch_req);
    end
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    tests_run++;
    if (fetch_req !== 1'b0 || fetch_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL ackdue_retire: got req=%b ovr=%b want 0 0", fetch_req, fetch_ovr);
    end
  endtask

  task automatic test_mid_reset();
    logic found = 1'b0;
    logic [36:0] a, e;
    fetch_ack = 1'b0;
    apply_reset(2);
    for (int c = 0; c < int'(FT); c++) begin
      tick();
      if (x == 11'(H_ACTIVE + 2) && y == 10'd6) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found || fetch_req !== 1'b1 || fetch_ovr !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_setup: got found=%b req=%b ovr=%b want 1 1 1", found, fetch_req, fetch_ovr);
    end
    RST = 1'b1;
    e = {11'd0, 10'd0, 1'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, 10'd0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      tick();
      a = {x, y, de, hsync, vsync, frame_start, fetch_req, fetch_line, fetch_ovr};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL midrst_hold %0d: got %h want %h", i, a, e);
      end
    end
    RST = 1'b0;
    tick();
    e = {11'd0, 10'd0, 1'b1, ~HS_POL, ~VS_POL, 1'b1, 1'b0, 10'd0, 1'b0};
    a = {x, y, de, hsync, vsync, frame_start, fetch_req, fetch_line, fetch_ovr};
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("FAIL midrst_restart: got %h want %h", a, e);
    end
  endtask

  initial begin
    test_reset();
    test_random_frames();
    test_sync_edges();
    test_fetch_ack_high();
    test_overrun();
    test_ack_on_due();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
